// File: rtl/decode_queue.sv
// Multi-lane circular instruction queue between fetch and decode.
// Optional same-cycle bypass when empty: define DECODE_QUEUE_BYPASS_EN.
module decode_queue #(
   parameter int DEPTH     = 8,
   parameter int PAYLOAD_W = 70,
   parameter int LANES     = 2,
   localparam int CW = $clog2(LANES + 1),
   localparam int PW = $clog2(DEPTH),
   localparam int OW = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [CW-1:0]              in_count,
   input  logic [LANES*PAYLOAD_W-1:0] in_payload,
   output logic                       in_ready,
   output logic [LANES-1:0]           out_valid,
   output logic [LANES*PAYLOAD_W-1:0] out_payload,
   input  logic [CW-1:0]              out_accept,
   output logic [OW-1:0]              occupancy
);

   logic [DEPTH-1:0][PAYLOAD_W-1:0] mem_q, mem_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [OW-1:0] occ_q, occ_d;
   logic          byp;
   int            enq_avail, skip, deq, n_wr;

   always_comb begin
      in_ready = (DEPTH - int'(occ_q)) >= LANES;
      byp = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
      byp = (occ_q == '0) && !flush && !rst;
`endif
      enq_avail = in_ready ? int'(in_count) : 0;
      // Bypassed lanes taken by decode this cycle never land in storage.
      skip = 0;
      if (byp) skip = (int'(out_accept) < enq_avail) ? int'(out_accept) : enq_avail;
      deq  = byp ? 0 : int'(out_accept);
      n_wr = enq_avail - skip;

      mem_d = mem_q;
      for (int i = 0; i < LANES; i++) begin
         if (i >= skip && i < enq_avail)
            mem_d[tail_q + PW'(i - skip)] = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
      end

      out_valid   = '0;
      out_payload = '0;
      for (int i = 0; i < LANES; i++) begin
         if (byp) begin
            if (i < int'(in_count)) begin
               out_valid[i] = 1'b1;
               out_payload[i*PAYLOAD_W +: PAYLOAD_W] = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
         end else if (int'(occ_q) > i) begin
            out_valid[i] = 1'b1;
            out_payload[i*PAYLOAD_W +: PAYLOAD_W] = mem_q[head_q + PW'(i)];
         end
      end

      if (flush) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         head_d = head_q + PW'(deq);
         tail_d = tail_q + PW'(n_wr);
         occ_d  = OW'(int'(occ_q) + n_wr - deq);
      end
   end

   assign occupancy = occ_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   // Storage is left dirty on reset/flush; occupancy gates every read.
   always_ff @(posedge clk) begin
      if (!rst && !flush) mem_q <= mem_d;
   end

endmodule
